// File: rtl/mul_unit_if.sv
// Issue/result bundle between the reservation station and the multiply unit.
// Latency: none, this file carries wiring only.
// Backpressure: fu_free and result_ack carry flow control in opposite directions.
interface mul_unit_if #(
  parameter int RS_W = 4
);
  logic            exe_valid;
  logic [31:0]     exe_src1;
  logic [31:0]     exe_src2;
  logic [31:0]     exe_imm;
  logic [3:0]      op;
  logic [2:0]      func;
  logic [RS_W-1:0] exe_rs;
  logic            fu_free;
  logic [31:0]     exe_data;
  logic            exe_data_valid;
  logic [RS_W-1:0] finished_rs;
  logic            result_ack;
  logic            flush;

  // Reservation-station side: issues work and consumes results.
  modport master (
    output exe_valid, exe_src1, exe_src2, exe_imm, op, func, exe_rs,
    output result_ack, flush,
    input  fu_free, exe_data, exe_data_valid, finished_rs
  );

  // Functional-unit side.
  modport slave (
    input  exe_valid, exe_src1, exe_src2, exe_imm, op, func, exe_rs,
    input  result_ack, flush,
    output fu_free, exe_data, exe_data_valid, finished_rs
  );
endinterface

// File: rtl/mul_unit.sv
// Pipelined 32x32 integer multiply unit answering the reservation station issue port.
// Latency: LAT cycles from accepted issue to registered result; one result per cycle.
// Backpressure: an unacked result freezes every stage and drops fu_free; flush squashes all.
module mul_unit #(
  parameter int         LAT       = 3,
  parameter int         RS_SZ     = 16,
  parameter logic [3:0] OP_ALUIMM = 4'd1
) (
  input logic       clk,
  input logic       rst,
  mul_unit_if.slave bus
);

  localparam int RS_W = $clog2(RS_SZ);
  // Stages ahead of the output register; at least one so the array stays legal.
  localparam int NP = (LAT > 1) ? LAT - 1 : 1;

  localparam logic [2:0] FN_MULH  = 3'd1;
  localparam logic [2:0] FN_MULHU = 3'd2;

  typedef struct packed {
    logic            vld;
    logic [RS_W-1:0] tag;
    logic [2:0]      func;
    logic [63:0]     prod;
  } stage_t;

  logic [31:0]     opa;
  logic [31:0]     opb;
  logic [63:0]     a_ext;
  logic [63:0]     b_ext;
  stage_t          issue_st;
  stage_t          feed;
  logic [31:0]     feed_res;
  stage_t          pipe [NP];
  logic            stall;
  logic            accept;
  logic            out_vld;
  logic [31:0]     out_data;
  logic [RS_W-1:0] out_rs;

  assign stall       = out_vld && !bus.result_ack;
  assign bus.fu_free = !stall && !rst;
  assign accept      = bus.exe_valid && bus.fu_free && !bus.flush;

  // Operand select and 64-bit product of the incoming issue. A 64x64 product
  // truncated to 64 bits is exact for both signed and unsigned operands once the
  // operands are extended the right way, so only Mulh sign-extends.
  always_comb begin
    opa   = bus.exe_src1;
    opb   = (bus.op == OP_ALUIMM) ? bus.exe_imm : bus.exe_src2;
    a_ext = {32'd0, opa};
    b_ext = {32'd0, opb};
    if (bus.func == FN_MULH) begin
      a_ext = {{32{opa[31]}}, opa};
      b_ext = {{32{opb[31]}}, opb};
    end
    issue_st      = '0;
    issue_st.vld  = accept;
    issue_st.tag  = bus.exe_rs;
    issue_st.func = bus.func;
    issue_st.prod = a_ext * b_ext;
  end

  // Pick the entry that lands in the output register next and its result half.
  always_comb begin
    feed     = (LAT > 1) ? pipe[NP-1] : issue_st;
    feed_res = ((feed.func == FN_MULH) || (feed.func == FN_MULHU)) ?
               feed.prod[63:32] : feed.prod[31:0];
  end

  // Pipeline advance; reset beats flush, flush beats stall and result_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) pipe[i] <= '0;
      out_vld  <= 1'b0;
      out_data <= 32'd0;
      out_rs   <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NP; i++) pipe[i].vld <= 1'b0;
      out_vld <= 1'b0;
    end else if (!stall) begin
      pipe[0] <= issue_st;
      for (int i = 1; i < NP; i++) pipe[i] <= pipe[i-1];
      out_vld  <= feed.vld;
      out_data <= feed_res;
      out_rs   <= feed.tag;
    end
  end

  assign bus.exe_data       = out_data;
  assign bus.exe_data_valid = out_vld;
  assign bus.finished_rs    = out_rs;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: arithmetic, immediate select, throughput,
// backpressure, flush and reset, each against hand-computed results.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mul_unit;

  localparam logic [2:0] MULL  = 3'd0;
  localparam logic [2:0] MULH  = 3'd1;
  localparam logic [2:0] MULHU = 3'd2;
  localparam logic [3:0] OP_ALU    = 4'd0;
  localparam logic [3:0] OP_ALUIMM = 4'd1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_unit_if #(.RS_W(4)) bus ();

  mul_unit #(.LAT(3), .RS_SZ(16), .OP_ALUIMM(OP_ALUIMM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issuing into a busy unit is a protocol violation on the bench side.
  always @(negedge clk) begin
    assert (!(bus.exe_valid === 1'b1 && bus.fu_free !== 1'b1)) else begin
      errors++;
      $error("FAIL proto_issue_while_busy observed exe_valid=1 fu_free=%b required no issue", bus.fu_free);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [31:0] data,
                            input logic [3:0] rs);
    chk({tag, "_vld"}, 32'(bus.exe_data_valid), 32'(vld));
    if (vld) begin
      chk({tag, "_data"}, bus.exe_data, data);
      chk({tag, "_rs"}, 32'(bus.finished_rs), 32'(rs));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [3:0] rs);
    bus.exe_valid = 1'b1;
    bus.func      = f;
    bus.op        = o;
    bus.exe_src1  = a;
    bus.exe_src2  = b;
    bus.exe_imm   = imm;
    bus.exe_rs    = rs;
  endtask

  task automatic idle();
    bus.exe_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.exe_valid  = 1'b0;
    bus.exe_src1   = 32'd0;
    bus.exe_src2   = 32'd0;
    bus.exe_imm    = 32'd0;
    bus.op         = OP_ALU;
    bus.func       = MULL;
    bus.exe_rs     = 4'd0;
    bus.result_ack = 1'b1;
    bus.flush      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_fu_free", 32'(bus.fu_free), 32'd0);
    chk("rst_vld", 32'(bus.exe_data_valid), 32'd0);
    chk("rst_data", bus.exe_data, 32'd0);
    chk("rst_rs", 32'(bus.finished_rs), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_fu_free", 32'(bus.fu_free), 32'd1);

    // Single Mull: 7 * -3 = -21, three cycles later, gone the cycle after
    issue(MULL, OP_ALU, 32'd7, 32'hFFFF_FFFD, 32'd0, 4'd5);
    tick(); idle();
    expect_out("mull_t1", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("mull_t2", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("mull_t3", 1'b1, 32'hFFFF_FFEB, 4'd5);
    tick();
    expect_out("mull_t4", 1'b0, 32'd0, 4'd0);

    // Back-to-back corner products, tags 1..3, fu_free held high
    issue(MULH, OP_ALU, 32'h8000_0000, 32'h8000_0000, 32'd0, 4'd1);
    chk("b2b_free0", 32'(bus.fu_free), 32'd1);
    tick();
    issue(MULHU, OP_ALU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd2);
    chk("b2b_free1", 32'(bus.fu_free), 32'd1);
    tick();
    issue(MULL, OP_ALU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd3);
    chk("b2b_free2", 32'(bus.fu_free), 32'd1);
    tick(); idle();
    expect_out("b2b_mulh", 1'b1, 32'h4000_0000, 4'd1);
    chk("b2b_free3", 32'(bus.fu_free), 32'd1);
    tick();
    expect_out("b2b_mulhu", 1'b1, 32'hFFFF_FFFE, 4'd2);
    chk("b2b_free4", 32'(bus.fu_free), 32'd1);
    tick();
    expect_out("b2b_mull", 1'b1, 32'h0000_0001, 4'd3);
    tick();
    expect_out("b2b_drain", 1'b0, 32'd0, 4'd0);

    // Immediate select, signedness of the high half, unknown func as Mull
    issue(MULL, OP_ALUIMM, 32'd12, 32'd99, 32'd10, 4'd4);
    tick();
    issue(MULL, OP_ALU, 32'd12, 32'd99, 32'd10, 4'd6);
    tick();
    issue(MULH, OP_ALU, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd7);
    tick();
    expect_out("aluimm", 1'b1, 32'd120, 4'd4);
    issue(MULHU, OP_ALU, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd8);
    tick();
    expect_out("alu_src2", 1'b1, 32'd1188, 4'd6);
    issue(3'd5, OP_ALU, 32'd3, 32'd5, 32'd0, 4'd9);
    tick(); idle();
    expect_out("mulh_neg", 1'b1, 32'hFFFF_FFFF, 4'd7);
    tick();
    expect_out("mulhu_neg", 1'b1, 32'h0000_0001, 4'd8);
    tick();
    expect_out("func5_mull", 1'b1, 32'd15, 4'd9);
    tick();
    expect_out("mix_drain", 1'b0, 32'd0, 4'd0);

    // Backpressure: results held while result_ack is low
    issue(MULL, OP_ALU, 32'd2, 32'd3, 32'd0, 4'd1);
    tick();
    issue(MULL, OP_ALU, 32'd4, 32'd5, 32'd0, 4'd2);
    tick();
    issue(MULL, OP_ALU, 32'd6, 32'd7, 32'd0, 4'd3);
    tick(); idle();
    bus.result_ack = 1'b0;
    #1;
    expect_out("bp_hold3", 1'b1, 32'd6, 4'd1);
    chk("bp_free3", 32'(bus.fu_free), 32'd0);
    tick();
    expect_out("bp_hold4", 1'b1, 32'd6, 4'd1);
    chk("bp_free4", 32'(bus.fu_free), 32'd0);
    tick();
    bus.result_ack = 1'b1;
    #1;
    expect_out("bp_tag1", 1'b1, 32'd6, 4'd1);
    chk("bp_free5", 32'(bus.fu_free), 32'd1);
    tick();
    expect_out("bp_tag2", 1'b1, 32'd20, 4'd2);
    tick();
    expect_out("bp_tag3", 1'b1, 32'd42, 4'd3);
    tick();
    expect_out("bp_drain", 1'b0, 32'd0, 4'd0);

    // Flush squashes in-flight work and the same-cycle issue
    issue(MULL, OP_ALU, 32'd11, 32'd2, 32'd0, 4'd10);
    tick();
    issue(MULL, OP_ALU, 32'd11, 32'd3, 32'd0, 4'd11);
    tick();
    issue(MULL, OP_ALU, 32'd11, 32'd4, 32'd0, 4'd12);
    bus.flush = 1'b1;
    tick(); idle();
    bus.flush = 1'b0;
    #1;
    chk("fl_free", 32'(bus.fu_free), 32'd1);
    expect_out("fl_c3", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("fl_c4", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("fl_c5", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("fl_c6", 1'b0, 32'd0, 4'd0);
    issue(MULL, OP_ALU, 32'd5, 32'd5, 32'd0, 4'd13);
    tick(); idle();
    expect_out("fl_re1", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("fl_re2", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("fl_restart", 1'b1, 32'd25, 4'd13);

    // Reset mid-operation clears everything, outputs included
    bus.exe_src1 = 32'h1234_5678;
    bus.exe_src2 = 32'h0000_0003;
    tick();
    issue(MULL, OP_ALU, 32'd9, 32'd9, 32'd0, 4'd1);
    tick();
    issue(MULL, OP_ALU, 32'd9, 32'd8, 32'd0, 4'd2);
    tick(); idle();
    rst = 1'b1;
    #1;
    chk("rr_free_in_rst", 32'(bus.fu_free), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rr_vld", 32'(bus.exe_data_valid), 32'd0);
    chk("rr_data", bus.exe_data, 32'd0);
    chk("rr_rs", 32'(bus.finished_rs), 32'd0);
    chk("rr_free", 32'(bus.fu_free), 32'd1);
    tick();
    expect_out("rr_c4", 1'b0, 32'd0, 4'd0);
    tick();
    expect_out("rr_c5", 1'b0, 32'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
